// File: rtl/gcd_job_ctrl.sv
// Job sequencer and CSR block for the GCD accelerator: launch, lock, completion/timeout/abort, flush, IRQ.
// Define GCD_JOB_CTRL_PERF_EN to make CYCLE_COUNT (0x18) and JOB_COUNT (0x20) readable.
module gcd_job_ctrl #(
  parameter int CNT_W        = 32,
  parameter int JOB_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        SRAM_CEn,
  input  logic [31:0] SRAM_ADDR,
  input  logic [63:0] SRAM_WDATA,
  input  logic        SRAM_WEn,
  input  logic [7:0]  SRAM_WBEn,
  output logic [63:0] SRAM_RDATA,
  output logic        GCD_START,
  output logic        GCD_SRSTn,
  input  logic        GCD_DONE,
  output logic        ARG_LOCK,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FLUSH} state_t;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t           state, state_nx;
  logic [FW-1:0]    flush_cnt;
  logic [CNT_W-1:0] run_cnt, tmo_limit;
  logic             done_q, irq_en;
  logic             done_st, tmo_st, abt_st, serr_st;
  logic             launch, set_done, set_tmo, set_abt, set_serr;
  logic [63:0]      bmask, rd_val;
  logic [3:0]       w1c;

  logic [2:0] sel;
  logic       wr, rd, start_wr, abort_wr, done_edge, tmo_hit, busy;
  assign sel       = SRAM_ADDR[5:3];
  assign wr        = ~SRAM_CEn & ~SRAM_WEn;
  assign rd        = ~SRAM_CEn & SRAM_WEn;
  assign start_wr  = wr && sel == 3'd0 && !SRAM_WBEn[0] && SRAM_WDATA[0];
  assign abort_wr  = wr && sel == 3'd0 && !SRAM_WBEn[0] && SRAM_WDATA[1];
  assign done_edge = GCD_DONE & ~done_q;
  assign tmo_hit   = (tmo_limit != '0) && (run_cnt == tmo_limit);
  assign busy      = (state != IDLE);
  assign w1c       = (wr && sel == 3'd1 && !SRAM_WBEn[0]) ? SRAM_WDATA[4:1] : 4'd0;
  assign set_serr  = start_wr && !abort_wr && busy;

  always_comb begin
    for (int b = 0; b < 8; b++) bmask[8*b +: 8] = {8{~SRAM_WBEn[b]}};
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nx;
  end

  // Completion outranks timeout/abort in the same cycle.
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    set_done = 1'b0;
    set_tmo  = 1'b0;
    set_abt  = 1'b0;
    case (state)
      IDLE:   if (start_wr && !abort_wr) begin
                launch   = 1'b1;
                state_nx = LAUNCH;
              end
      LAUNCH: state_nx = RUN;
      RUN:    if (done_edge) begin
                set_done = 1'b1;
                state_nx = IDLE;
              end else if (tmo_hit || abort_wr) begin
                set_tmo  = tmo_hit;
                set_abt  = abort_wr;
                state_nx = FLUSH;
              end
      FLUSH:  if (flush_cnt == FW'(FLUSH_CYCLES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign GCD_START = (state == LAUNCH);
  assign GCD_SRSTn = (state != FLUSH);
  assign ARG_LOCK  = busy;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      flush_cnt <= '0;
      run_cnt   <= '0;
      tmo_limit <= '0;
      done_q    <= 1'b0;
      irq_en    <= 1'b0;
      done_st   <= 1'b0;
      tmo_st    <= 1'b0;
      abt_st    <= 1'b0;
      serr_st   <= 1'b0;
      IRQ       <= 1'b0;
    end else begin
      done_q    <= GCD_DONE;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (launch)                               run_cnt <= '0;
      else if (state == RUN && run_cnt != '1)   run_cnt <= run_cnt + 1'b1;
      if (wr && sel == 3'd0 && !SRAM_WBEn[1])   irq_en <= SRAM_WDATA[8];
      if (wr && sel == 3'd2)
        tmo_limit <= (tmo_limit & ~bmask[CNT_W-1:0]) | (SRAM_WDATA[CNT_W-1:0] & bmask[CNT_W-1:0]);
      // Hardware set beats a simultaneous W1C.
      done_st <= (done_st & ~w1c[0]) | set_done;
      tmo_st  <= (tmo_st  & ~w1c[1]) | set_tmo;
      abt_st  <= (abt_st  & ~w1c[2]) | set_abt;
      serr_st <= (serr_st & ~w1c[3]) | set_serr;
      IRQ     <= irq_en & (done_st | tmo_st | abt_st);
    end
  end

`ifdef GCD_JOB_CTRL_PERF_EN
  logic [JOB_W-1:0] job_cnt;
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)       job_cnt <= '0;
    else if (set_done) job_cnt <= job_cnt + 1'b1;
  end
`endif

  always_comb begin
    rd_val = '0;
    case (sel)
      3'd0: rd_val[8]         = irq_en;
      3'd1: rd_val[4:0]       = {serr_st, abt_st, tmo_st, done_st, busy};
      3'd2: rd_val[CNT_W-1:0] = tmo_limit;
`ifdef GCD_JOB_CTRL_PERF_EN
      3'd3: rd_val[CNT_W-1:0] = run_cnt;
      3'd4: rd_val[JOB_W-1:0] = job_cnt;
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)  SRAM_RDATA <= '0;
    else if (rd)  SRAM_RDATA <= rd_val;
  end

  logic unused_ok;
  assign unused_ok = ^{SRAM_ADDR[31:6], SRAM_ADDR[2:0], SRAM_WDATA, bmask};
endmodule
